// File: rtl/cmp_meter_pkg.sv
// Shared types and constants for the comparator pulse-width meter.
// The optional statistics block is enabled by defining CMP_WIDTH_STATS_EN.
package cmp_meter_pkg;

    // Default result/counter width in bits.
    localparam int CMP_CNT_W_DEF = 16;

    // Measurement FSM states. The top keeps the state in a plain logic
    // vector and uses localparam aliases of these encodings.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_e;

    // One finished measurement at the default width.
    typedef struct packed {
        logic [CMP_CNT_W_DEF-1:0] data;
        logic                     sat;
    } width_res_t;

endpackage : cmp_meter_pkg

// File: rtl/cmp_sync_edge.sv
// Synchronizer for the asynchronous comparator output plus rise/fall
// detection on the synchronized level. The edge outputs are combinational
// compares of the synchronized level against its one-cycle-delayed copy.
module cmp_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic cmp_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   dly_q;
    logic                   dly_d;

    // Shift the raw input through the synchronizer chain; stage 0 samples d.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        dly_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and delay flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign cmp_s = sync_q[SYNC_STAGES-1];
    assign rise  = cmp_s & ~dly_q;
    assign fall  = ~cmp_s & dly_q;

endmodule : cmp_sync_edge

// File: rtl/cmp_pulse_width_meter.sv
// Measures the high time of a comparator output in clk cycles and hands
// each width to a consumer through a one-entry valid/ready output register.
// Defining CMP_WIDTH_STATS_EN adds min/max/count statistics over all
// committed widths, including ones dropped at the output.
//
// Output handshake: a result is transferred on any cycle where
// width_valid & width_ready are both high. While width_valid is high and
// width_ready low, width_data/width_sat hold stable. A new result arriving
// in the same cycle as a transfer replaces the entry with no bubble; one
// arriving while the entry is held is discarded and flagged on drop.
module cmp_pulse_width_meter
    import cmp_meter_pkg::*;
#(
    parameter int CNT_W       = CMP_CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WIDTH   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmp_in,
    input  logic             width_ready,
    output logic             width_valid,
    output logic [CNT_W-1:0] width_data,
    output logic             width_sat,
    output logic             drop,
    output logic             busy,
    output logic [1:0]       state_dbg
`ifdef CMP_WIDTH_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_min,
    output logic [CNT_W-1:0] stat_max,
    output logic [CNT_W-1:0] stat_cnt
`endif
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ARMED   = ST_ARMED;
    localparam logic [1:0] S_MEASURE = ST_MEASURE;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

    // Synchronized comparator level and its edges.
    logic cmp_s;
    logic rise;
    logic fall;

    cmp_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (cmp_in),
        .cmp_s(cmp_s),
        .rise (rise),
        .fall (fall)
    );

    // Measurement state.
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             psat_q, psat_d;
    logic             commit;

    // Output register.
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             drop_q, drop_d;
    logic             xfer;

    // FSM and width counter: arm on a low level, count while high, commit on fall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        psat_d  = psat_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Never start mid-pulse: wait for the low level first.
                if (en && !cmp_s) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_ONE;
                    psat_d  = 1'b0;
                end
            end
            S_MEASURE: begin
                if (!en) begin
                    // Abort: the partial pulse produces no result.
                    state_d = S_IDLE;
                end else if (fall) begin
                    state_d = S_ARMED;
                    commit  = (cnt_q >= MIN_W);
                end else if (cmp_s) begin
                    if (cnt_q == CNT_MAX) begin
                        psat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Measurement registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            psat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            psat_q  <= psat_d;
        end
    end

    // One-entry output register: load when empty or draining, else flag a drop.
    always_comb begin
        xfer        = out_valid_q & width_ready;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        drop_d      = 1'b0;
        if (commit) begin
            if (!out_valid_q || xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = cnt_q;
                out_sat_d   = psat_q;
            end else begin
                drop_d = 1'b1;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            drop_q      <= drop_d;
        end
    end

    assign width_valid = out_valid_q;
    assign width_data  = out_data_q;
    assign width_sat   = out_sat_q;
    assign drop        = drop_q;
    assign busy        = (state_q == S_MEASURE);
    assign state_dbg   = state_q;

`ifdef CMP_WIDTH_STATS_EN
    logic [CNT_W-1:0] stat_min_q, stat_min_d;
    logic [CNT_W-1:0] stat_max_q, stat_max_d;
    logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;

    // Running statistics over every committed width; clear wins over a commit.
    always_comb begin
        stat_min_d = stat_min_q;
        stat_max_d = stat_max_q;
        stat_cnt_d = stat_cnt_q;
        if (stat_clr) begin
            stat_min_d = '1;
            stat_max_d = '0;
            stat_cnt_d = '0;
        end else if (commit) begin
            if (cnt_q < stat_min_q) begin
                stat_min_d = cnt_q;
            end
            if (cnt_q > stat_max_q) begin
                stat_max_d = cnt_q;
            end
            if (stat_cnt_q != CNT_MAX) begin
                stat_cnt_d = stat_cnt_q + CNT_ONE;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_min_q <= '1;
            stat_max_q <= '0;
            stat_cnt_q <= '0;
        end else begin
            stat_min_q <= stat_min_d;
            stat_max_q <= stat_max_d;
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_min = stat_min_q;
    assign stat_max = stat_max_q;
    assign stat_cnt = stat_cnt_q;
`endif

endmodule : cmp_pulse_width_meter

// File: tb/tb_cmp_pulse_width_meter.sv
// Self-checking bench for cmp_pulse_width_meter (CNT_W=4, MIN_WIDTH=3,
// SYNC_STAGES=2). Define CMP_WIDTH_STATS_EN to also exercise the statistics.
module tb_cmp_pulse_width_meter;
    import cmp_meter_pkg::*;

    localparam int TB_CNT_W = 4;
    localparam int TB_MIN   = 3;
    localparam int TB_SYNC  = 2;
    localparam int TB_MAX   = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                en = 1'b0;
    logic                cmp_in = 1'b0;
    logic                width_ready = 1'b0;
    logic                width_valid;
    logic [TB_CNT_W-1:0] width_data;
    logic                width_sat;
    logic                drop;
    logic                busy;
    logic [1:0]          state_dbg;
`ifdef CMP_WIDTH_STATS_EN
    logic                stat_clr = 1'b0;
    logic [TB_CNT_W-1:0] stat_min;
    logic [TB_CNT_W-1:0] stat_max;
    logic [TB_CNT_W-1:0] stat_cnt;
`endif

    cmp_pulse_width_meter #(
        .CNT_W      (TB_CNT_W),
        .SYNC_STAGES(TB_SYNC),
        .MIN_WIDTH  (TB_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cmp_in     (cmp_in),
        .width_ready(width_ready),
        .width_valid(width_valid),
        .width_data (width_data),
        .width_sat  (width_sat),
        .drop       (drop),
        .busy       (busy),
        .state_dbg  (state_dbg)
`ifdef CMP_WIDTH_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_cnt   (stat_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state: expected {sat, data} per delivered result.
    logic [TB_CNT_W:0] exp_q[$];
    int n_checks   = 0;
    int n_pass     = 0;
    int n_unexp    = 0;
    int drop_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n clock edges, settling 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one high pulse of len cycles followed by gap low cycles. When the
    // result is expected to reach the consumer, push the modelled width.
    task automatic pulse(input int len, input int gap, input bit delivered);
        logic [TB_CNT_W:0] e;
        if (delivered && len >= TB_MIN) begin
            if (len > TB_MAX) e = {1'b1, TB_CNT_W'(TB_MAX)};
            else              e = {1'b0, TB_CNT_W'(len)};
            exp_q.push_back(e);
        end
        cmp_in = 1'b1;
        tick(len);
        cmp_in = 1'b0;
        tick(gap);
    endtask

    // Consumer-side monitor: every transfer pops and compares.
    always @(negedge clk) begin
        logic [TB_CNT_W:0] e;
        if (rst && width_valid && width_ready) begin
            if (exp_q.size() == 0) begin
                n_unexp++;
                $display("FAIL unexpected_result: got data %0d expected none", width_data);
            end else begin
                e = exp_q.pop_front();
                check_eq("width_data", 32'(width_data), 32'(e[TB_CNT_W-1:0]));
                check_eq("width_sat", 32'(width_sat), 32'(e[TB_CNT_W]));
            end
        end
        if (rst && drop) drop_cnt++;
    end

    initial begin
        int lat;
        int drops0;

        // Reset
        rst = 1'b0;
        tick(3);
        check_eq("rst_valid", 32'(width_valid), 0);
        check_eq("rst_data", 32'(width_data), 0);
        check_eq("rst_sat", 32'(width_sat), 0);
        check_eq("rst_drop", 32'(drop), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b1;
        en  = 1'b1;
        tick(3);

        // 10-cycle pulse, fall-to-valid latency, then consume.
        exp_q.push_back({1'b0, TB_CNT_W'(10)});
        cmp_in = 1'b1;
        tick(5);
        check_eq("busy_mid", 32'(busy), 1);
        check_eq("state_mid", 32'(state_dbg), 32'(ST_MEASURE));
        tick(5);
        cmp_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            if (width_valid) begin
                lat = k;
                break;
            end
        end
        check_eq("valid_latency", 32'(lat), 32'(TB_SYNC + 1));
        check_eq("data_10", 32'(width_data), 10);
        width_ready = 1'b1;
        tick(2);
        check_eq("valid_cleared", 32'(width_valid), 0);
        tick(4);

        // Glitch filtering around MIN_WIDTH.
        drops0 = drop_cnt;
        pulse(2, 6, 1);
        pulse(5, 6, 1);
        pulse(1, 6, 1);
        pulse(3, 6, 1);
        check_eq("no_drop_min", 32'(drop_cnt - drops0), 0);

        // Held output and drop on a second commit.
        width_ready = 1'b0;
        drops0 = drop_cnt;
        pulse(4, 6, 1);
        pulse(6, 6, 0);
        check_eq("drop_once", 32'(drop_cnt - drops0), 1);
        check_eq("held_valid", 32'(width_valid), 1);
        check_eq("held_data", 32'(width_data), 4);
        width_ready = 1'b1;
        tick(4);
        check_eq("drained_after_drop", 32'(width_valid), 0);

        // Saturation and the exact-maximum boundary.
        pulse(40, 6, 1);
        pulse(3, 6, 1);
        pulse(TB_MAX, 6, 1);
        pulse(TB_MAX + 1, 6, 1);

        // Enable while already high: that pulse is ignored.
        en = 1'b0;
        tick(2);
        check_eq("idle_when_off", 32'(state_dbg), 32'(ST_IDLE));
        cmp_in = 1'b1;
        tick(3);
        en = 1'b1;
        tick(5);
        check_eq("no_start_mid_pulse", 32'(busy), 0);
        cmp_in = 1'b0;
        tick(6);
        pulse(7, 6, 1);

        // Abort by en=0 mid-pulse: no result.
        cmp_in = 1'b1;
        tick(5);
        en = 1'b0;
        tick(2);
        check_eq("abort_busy", 32'(busy), 0);
        cmp_in = 1'b0;
        tick(4);
        en = 1'b1;
        tick(3);
        check_eq("abort_no_valid", 32'(width_valid), 0);

        // Reset with a pending result and mid-pulse.
        width_ready = 1'b0;
        pulse(5, 6, 0);
        check_eq("pending_valid", 32'(width_valid), 1);
        cmp_in = 1'b1;
        tick(4);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(width_valid), 0);
        check_eq("mid_rst_data", 32'(width_data), 0);
        check_eq("mid_rst_busy", 32'(busy), 0);
        tick(2);
        cmp_in = 1'b0;
        rst = 1'b1;
        width_ready = 1'b1;
        tick(4);
        pulse(6, 6, 1);

`ifdef CMP_WIDTH_STATS_EN
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        pulse(8, 6, 1);
        pulse(3, 6, 1);
        pulse(12, 6, 1);
        check_eq("stat_min", 32'(stat_min), 3);
        check_eq("stat_max", 32'(stat_max), 12);
        check_eq("stat_cnt", 32'(stat_cnt), 3);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        check_eq("stat_min_clr", 32'(stat_min), 32'(TB_MAX));
        check_eq("stat_max_clr", 32'(stat_max), 0);
        check_eq("stat_cnt_clr", 32'(stat_cnt), 0);
`endif

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick(1);
        check_eq("queue_drained", 32'(exp_q.size()), 0);
        check_eq("no_unexpected", 32'(n_unexp), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_cmp_pulse_width_meter
